// File: rtl/pipe_sequencer.sv
// Frame-synchronous reconfiguration sequencer: applies requested settings only at
// frame boundaries, flushing and draining the stage FIFOs before structural changes.
module pipe_sequencer #(
    parameter int          FLUSH_CYCLES  = 16,
    parameter int          DRAIN_TIMEOUT = 1024,
    parameter logic [25:0] THRESH_INIT   = 26'd3000000
) (
    input  logic        i_sysclk,
    input  logic        db_rstn,
    input  logic        i_sof,
    input  logic        i_cfg_done,
    input  logic        i_req_mode,
    input  logic        i_req_gaussian,
    input  logic        i_req_sobel,
    input  logic        i_req_freeze,
    input  logic [25:0] i_req_threshold,
    input  logic [3:0]  i_empty,
    output logic        o_flush,
    output logic        o_mode,
    output logic        o_gaussian_enable,
    output logic        o_sobel_enable,
    output logic        o_freeze,
    output logic [25:0] o_threshold,
    output logic        o_busy,
    output logic [7:0]  o_reconfig_count,
    output logic        o_timeout
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_CFG, RUN, ARM, FLUSH, DRAIN, APPLY, WAIT_SOF, FROZEN
    } state_e;

    state_e      state_q, state_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic        snap_mode_q, snap_mode_d, snap_gauss_q, snap_gauss_d, snap_sobel_q, snap_sobel_d;
    logic [25:0] snap_thr_q, snap_thr_d;
    logic        mode_q, mode_d, gauss_q, gauss_d, sobel_q, sobel_d, freeze_q, freeze_d;
    logic [25:0] thr_q, thr_d;
    logic        flush_q, flush_d, busy_q, busy_d, timeout_q, timeout_d;
    logic [7:0]  count_q, count_d;
    logic        snap_ld, struct_diff, thr_diff;

    assign struct_diff = {i_req_mode, i_req_gaussian, i_req_sobel} != {mode_q, gauss_q, sobel_q};
    assign thr_diff    = i_req_threshold != thr_q;

    always_comb begin
        state_d   = state_q;
        snap_ld   = 1'b0;
        mode_d    = mode_q;
        gauss_d   = gauss_q;
        sobel_d   = sobel_q;
        freeze_d  = freeze_q;
        thr_d     = thr_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        // Losing camera configuration aborts whatever is in flight; applied values stay put.
        if (!i_cfg_done && state_q != WAIT_CFG) begin
            state_d = WAIT_CFG;
        end else begin
            case (state_q)
                WAIT_CFG: if (i_sof && i_cfg_done) begin
                    state_d = FLUSH;
                    snap_ld = 1'b1;
                end
                RUN: if (i_req_freeze || struct_diff || thr_diff) state_d = ARM;
                ARM: if (i_sof) begin
                    snap_ld = 1'b1;
                    if (i_req_freeze) begin
                        state_d  = FROZEN;
                        freeze_d = 1'b1;
                    end else if (struct_diff) begin
                        state_d = FLUSH;
                    end else begin
                        thr_d   = i_req_threshold;
                        state_d = RUN;
                    end
                end
                FLUSH: if (flush_cnt_q == FLUSH_LAST) state_d = DRAIN;
                DRAIN: if (&i_empty) begin
                    state_d = APPLY;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d   = APPLY;
                    timeout_d = 1'b1;
                end
                APPLY: begin
                    mode_d   = snap_mode_q;
                    gauss_d  = snap_gauss_q;
                    sobel_d  = snap_sobel_q;
                    thr_d    = snap_thr_q;
                    freeze_d = 1'b0;
                    count_d  = count_q + 8'd1;
                    state_d  = WAIT_SOF;
                end
                WAIT_SOF: if (i_sof) state_d = RUN;
                FROZEN: if (!i_req_freeze) begin
                    snap_ld = 1'b1;
                    state_d = FLUSH;
                end
                default: state_d = WAIT_CFG;
            endcase
        end
        snap_mode_d  = snap_ld ? i_req_mode      : snap_mode_q;
        snap_gauss_d = snap_ld ? i_req_gaussian  : snap_gauss_q;
        snap_sobel_d = snap_ld ? i_req_sobel     : snap_sobel_q;
        snap_thr_d   = snap_ld ? i_req_threshold : snap_thr_q;
        // Flush/busy are registered from the next state so they track the state register.
        flush_d     = (state_d != RUN) && (state_d != ARM);
        busy_d      = state_d != RUN;
        flush_cnt_d = (state_q == FLUSH && state_d == FLUSH) ? flush_cnt_q + 1'b1 : '0;
        drain_cnt_d = (state_q == DRAIN && state_d == DRAIN) ? drain_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            state_q      <= WAIT_CFG;
            flush_cnt_q  <= '0;
            drain_cnt_q  <= '0;
            snap_mode_q  <= 1'b0;
            snap_gauss_q <= 1'b0;
            snap_sobel_q <= 1'b0;
            snap_thr_q   <= THRESH_INIT;
            mode_q       <= 1'b0;
            gauss_q      <= 1'b0;
            sobel_q      <= 1'b0;
            freeze_q     <= 1'b0;
            thr_q        <= THRESH_INIT;
            flush_q      <= 1'b1;
            busy_q       <= 1'b1;
            count_q      <= 8'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            snap_mode_q  <= snap_mode_d;
            snap_gauss_q <= snap_gauss_d;
            snap_sobel_q <= snap_sobel_d;
            snap_thr_q   <= snap_thr_d;
            mode_q       <= mode_d;
            gauss_q      <= gauss_d;
            sobel_q      <= sobel_d;
            freeze_q     <= freeze_d;
            thr_q        <= thr_d;
            flush_q      <= flush_d;
            busy_q       <= busy_d;
            count_q      <= count_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_flush           = flush_q;
    assign o_mode            = mode_q;
    assign o_gaussian_enable = gauss_q;
    assign o_sobel_enable    = sobel_q;
    assign o_freeze          = freeze_q;
    assign o_threshold       = thr_q;
    assign o_busy            = busy_q;
    assign o_reconfig_count  = count_q;
    assign o_timeout         = timeout_q;
endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: bring-up, table of reconfigurations,
// freeze, drain timeout, cfg loss and asynchronous reset.
module tb_pipe_sequencer;
    logic        clk = 1'b0;
    logic        db_rstn;
    logic        i_sof, i_cfg_done, i_req_mode, i_req_gaussian, i_req_sobel, i_req_freeze;
    logic [25:0] i_req_threshold;
    logic [3:0]  i_empty;
    logic        o_flush, o_mode, o_gaussian_enable, o_sobel_enable, o_freeze, o_busy, o_timeout;
    logic [25:0] o_threshold;
    logic [7:0]  o_reconfig_count;

    always #4 clk = ~clk;

    pipe_sequencer dut (
        .i_sysclk(clk), .db_rstn(db_rstn), .i_sof(i_sof), .i_cfg_done(i_cfg_done),
        .i_req_mode(i_req_mode), .i_req_gaussian(i_req_gaussian), .i_req_sobel(i_req_sobel),
        .i_req_freeze(i_req_freeze), .i_req_threshold(i_req_threshold), .i_empty(i_empty),
        .o_flush(o_flush), .o_mode(o_mode), .o_gaussian_enable(o_gaussian_enable),
        .o_sobel_enable(o_sobel_enable), .o_freeze(o_freeze), .o_threshold(o_threshold),
        .o_busy(o_busy), .o_reconfig_count(o_reconfig_count), .o_timeout(o_timeout)
    );

    typedef struct {
        logic        mode, gauss, sobel;
        logic [25:0] thr;
        logic        exp_flush;
    } vec_t;

    typedef struct {
        logic        mode, gauss, sobel;
        logic [25:0] thr;
        logic [7:0]  count;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        i_sof = 1'b1;
        tick();
        i_sof = 1'b0;
    endtask

    initial begin
        logic saw_flush;
        exp_t e;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 26'd100,      1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 26'd5000,     1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 26'd5000,     1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 26'h3FFFFFF,  1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 26'd0,        1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 26'd0,        1'b1};

        db_rstn = 1'b1; i_sof = 1'b0; i_cfg_done = 1'b0;
        i_req_mode = 1'b0; i_req_gaussian = 1'b0; i_req_sobel = 1'b0; i_req_freeze = 1'b0;
        i_req_threshold = 26'd3000000; i_empty = 4'hF;
        #2 db_rstn = 1'b0;
        #1;
        chk("rst_flush", o_flush, 1); chk("rst_busy", o_busy, 1);
        chk("rst_mode", o_mode, 0); chk("rst_gauss", o_gaussian_enable, 0);
        chk("rst_sobel", o_sobel_enable, 0); chk("rst_freeze", o_freeze, 0);
        chk("rst_thr", o_threshold, 26'd3000000); chk("rst_count", o_reconfig_count, 0);
        chk("rst_timeout", o_timeout, 0);
        tick(); tick();
        db_rstn = 1'b1;
        tick();

        // Bring-up: SOF without cfg_done is ignored
        pulse_sof();
        repeat (3) tick();
        chk("nocfg_flush", o_flush, 1); chk("nocfg_count", o_reconfig_count, 0);
        i_cfg_done = 1'b1;
        pulse_sof();
        chk("bringup_flush", o_flush, 1);
        repeat (17) tick();
        chk("bringup_count_pre", o_reconfig_count, 0);
        tick();
        chk("bringup_count", o_reconfig_count, 1);
        chk("bringup_wait_flush", o_flush, 1);
        pulse_sof();
        chk("bringup_run_flush", o_flush, 0); chk("bringup_run_busy", o_busy, 0);

        // Mode change held without SOF must not take effect
        i_req_mode = 1'b1;
        saw_flush = 1'b0;
        repeat (1000) begin
            tick();
            saw_flush |= o_flush;
        end
        chk("nosof_flush", saw_flush, 0); chk("nosof_mode", o_mode, 0);
        pulse_sof();
        chk("mode_flush", o_flush, 1);
        repeat (17) tick();
        chk("mode_pre_apply", o_mode, 0);
        tick();
        chk("mode_apply", o_mode, 1); chk("mode_count", o_reconfig_count, 2);
        pulse_sof();
        chk("mode_run_flush", o_flush, 0);
        exp_count = 8'd2;

        // Table of reconfigurations, checked through the scoreboard
        for (int i = 0; i < 6; i++) begin
            i_req_mode = vecs[i].mode; i_req_gaussian = vecs[i].gauss;
            i_req_sobel = vecs[i].sobel; i_req_threshold = vecs[i].thr;
            tick(); tick();
            if (vecs[i].exp_flush) exp_count++;
            sb.push_back('{vecs[i].mode, vecs[i].gauss, vecs[i].sobel, vecs[i].thr,
                           exp_count, vecs[i].exp_flush});
            pulse_sof();
            if (!vecs[i].exp_flush) chk("thr_one_cycle", o_threshold, vecs[i].thr);
            saw_flush = o_flush;
            repeat (25) begin
                tick();
                saw_flush |= o_flush;
            end
            pulse_sof();
            tick();
            e = sb.pop_front();
            chk("vec_mode", o_mode, e.mode); chk("vec_gauss", o_gaussian_enable, e.gauss);
            chk("vec_sobel", o_sobel_enable, e.sobel); chk("vec_thr", o_threshold, e.thr);
            chk("vec_count", o_reconfig_count, e.count); chk("vec_saw_flush", saw_flush, e.flush);
            chk("vec_run_flush", o_flush, 0); chk("vec_run_busy", o_busy, 0);
        end

        // Freeze wins over a simultaneous sobel change
        i_req_freeze = 1'b1; i_req_sobel = 1'b1;
        tick(); tick();
        pulse_sof();
        chk("frz_freeze", o_freeze, 1); chk("frz_flush", o_flush, 1); chk("frz_sobel", o_sobel_enable, 0);
        repeat (20) tick();
        chk("frz_hold_freeze", o_freeze, 1); chk("frz_hold_sobel", o_sobel_enable, 0);
        i_req_freeze = 1'b0;
        tick();
        repeat (17) tick();
        chk("unfrz_pre_freeze", o_freeze, 1);
        tick();
        chk("unfrz_sobel", o_sobel_enable, 1); chk("unfrz_freeze", o_freeze, 0);
        chk("unfrz_count", o_reconfig_count, 7);
        pulse_sof();
        chk("unfrz_busy", o_busy, 0);

        // Drain timeout with one FIFO never emptying
        i_empty = 4'b0111; i_req_mode = 1'b0;
        tick(); tick();
        pulse_sof();
        repeat (1039) tick();
        chk("to_pre", o_timeout, 0);
        tick();
        chk("to_set", o_timeout, 1); chk("to_mode_pre", o_mode, 1);
        tick();
        chk("to_mode", o_mode, 0); chk("to_count", o_reconfig_count, 8);
        i_empty = 4'hF;
        pulse_sof();
        chk("to_busy", o_busy, 0); chk("to_sticky", o_timeout, 1);

        // Lose cfg_done during DRAIN
        i_req_mode = 1'b1; i_empty = 4'h0;
        tick(); tick();
        pulse_sof();
        repeat (20) tick();
        i_cfg_done = 1'b0;
        tick();
        chk("cfgloss_flush", o_flush, 1); chk("cfgloss_busy", o_busy, 1);
        chk("cfgloss_mode", o_mode, 0); chk("cfgloss_count", o_reconfig_count, 8);
        tick(); tick();
        i_cfg_done = 1'b1; i_empty = 4'hF;
        pulse_sof();
        repeat (18) tick();
        chk("recfg_mode", o_mode, 1); chk("recfg_count", o_reconfig_count, 9);
        chk("recfg_timeout", o_timeout, 1);
        pulse_sof();
        chk("recfg_busy", o_busy, 0);

        // Asynchronous reset while frozen
        i_req_freeze = 1'b1;
        tick(); tick();
        pulse_sof();
        chk("frz2_freeze", o_freeze, 1);
        #2 db_rstn = 1'b0;
        #1;
        chk("arst_flush", o_flush, 1); chk("arst_busy", o_busy, 1);
        chk("arst_freeze", o_freeze, 0); chk("arst_mode", o_mode, 0);
        chk("arst_thr", o_threshold, 26'd3000000); chk("arst_count", o_reconfig_count, 0);
        chk("arst_timeout", o_timeout, 0);
        tick();
        db_rstn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Frame-synchronous reconfiguration sequencer for the 125 MHz processing chain: camera output FIFO, preprocess, Gaussian, Sobel, and memory interface. It takes the user's requested settings for mode, filter enables, Sobel threshold and freeze, and applies them only at frame boundaries. Before any change that alters the pixel format or pipeline depth, it flushes and drains every stage FIFO. It replaces direct wiring of control levels and `pipe_flush||sw_freeze` into the datapath, so the frame buffer never receives a torn or mixed-configuration frame.

## Interface
Parameters:
- FLUSH_CYCLES, 16: number of cycles `o_flush` is held in FLUSH before draining starts.
- DRAIN_TIMEOUT, 1024: maximum number of cycles spent in DRAIN waiting for all stage FIFOs to empty.
- THRESH_INIT, 26'd3000000: reset value of `o_threshold`.

Ports (name, direction, width, meaning):
- i_sysclk  in  1  125 MHz system clock; all logic is on its rising edge.
- db_rstn  in  1  asynchronous, active-low reset.
- i_sof  in  1  one-cycle start-of-frame pulse, synchronous to i_sysclk.
- i_cfg_done  in  1  level; camera register configuration is complete.
- i_req_mode  in  1  requested mode (1 = greyscale).
- i_req_gaussian  in  1  requested Gaussian enable.
- i_req_sobel  in  1  requested Sobel enable.
- i_req_freeze  in  1  requested frame freeze.
- i_req_threshold  in  26  requested Sobel threshold.
- i_empty  in  4  stage output FIFO empty flags {sobel, gaussian, pp, cam}.
- o_flush  out  1  pipeline flush to all stages.
- o_mode  out  1  applied mode.
- o_gaussian_enable  out  1  applied Gaussian enable.
- o_sobel_enable  out  1  applied Sobel enable.
- o_freeze  out  1  frame freeze is active.
- o_threshold  out  26  applied Sobel threshold.
- o_busy  out  1  high whenever the state is not RUN.
- o_reconfig_count  out  8  number of completed APPLY passes; wraps 255→0.
- o_timeout  out  1  sticky; set when any DRAIN times out, cleared only by reset.

## Operation
- All outputs are registered.
- Reset values:
  - state = WAIT_CFG
  - o_flush = 1, o_busy = 1
  - o_mode, o_gaussian_enable, o_sobel_enable, o_freeze = 0
  - o_threshold = THRESH_INIT
  - o_reconfig_count = 0, o_timeout = 0
- Structural difference: `{i_req_mode, i_req_gaussian, i_req_sobel}` differs from `{o_mode, o_gaussian_enable, o_sobel_enable}`.
- Threshold difference: `i_req_threshold` differs from `o_threshold`.
- States and transitions:
  - WAIT_CFG: o_flush=1. Exit to FLUSH on the first i_sof seen while i_cfg_done=1.
  - RUN: o_flush=0.
    - If i_req_freeze=1, or a structural difference exists, or a threshold difference exists → ARM.
  - ARM: o_flush=0. Wait for i_sof. On the i_sof cycle, capture a snapshot of all `i_req_*` inputs, then:
    - snapshot freeze=1 → FROZEN; set o_freeze=1 and o_flush=1. Freeze wins over any simultaneous change.
    - otherwise, structural difference → FLUSH.
    - otherwise, threshold only → load o_threshold from the snapshot and return to RUN. No flush, and o_reconfig_count does not increment.
    - otherwise (request reverted before the SOF) → RUN with no effect.
  - FLUSH: o_flush=1 for exactly FLUSH_CYCLES cycles, then DRAIN.
  - DRAIN: o_flush=1.
    - i_empty == 4'b1111 → APPLY.
    - DRAIN_TIMEOUT cycles elapsed without all flags empty → APPLY and set o_timeout.
  - APPLY: single cycle.
    - Load o_mode, o_gaussian_enable, o_sobel_enable and o_threshold from the snapshot.
    - o_freeze := 0.
    - o_reconfig_count += 1.
    - Next state WAIT_SOF.
  - WAIT_SOF: o_flush=1. On i_sof → RUN; o_flush falls the cycle after the SOF.
  - FROZEN: o_flush=1, o_freeze=1. Request changes are ignored.
    - When i_req_freeze=0, take a new snapshot and go to FLUSH. The pending configuration is applied in APPLY.
- Snapshot update rule: the snapshot is overwritten only on the ARM→x transition, the FROZEN→FLUSH transition, and the WAIT_CFG→FLUSH transition. Requests that change during FLUSH, DRAIN or WAIT_SOF are handled on a later RUN→ARM pass.
- i_cfg_done=0 in any state other than WAIT_CFG → WAIT_CFG on the next cycle. o_flush=1; applied values are retained.
- Counters:
  - FLUSH counter width is clog2(FLUSH_CYCLES+1).
  - DRAIN counter width is clog2(DRAIN_TIMEOUT+1).
  - Both counters clear on state entry.

## Timing
- i_sof is sampled at the clock edge. All actions tied to the SOF take effect in the following cycle.
- Sequence for a structural change, with SOF sampled at edge 0:
  - o_flush=1 at edges 1 through FLUSH_CYCLES.
  - DRAIN lasts at least 1 cycle.
  - APPLY outputs become visible one cycle after DRAIN exits.
- Threshold-only change: o_threshold updates 1 cycle after the SOF; o_flush stays 0 throughout.
- i_sof is ignored in FLUSH, DRAIN and APPLY.
- An i_sof pulse in the APPLY cycle is missed; WAIT_SOF waits for the next frame.
- db_rstn is asserted asynchronously in any state. Reset values appear immediately; release is synchronized upstream.

## Test plan
- **Reset and bring-up:** reset, then hold i_cfg_done=0 and pulse i_sof → o_flush stays 1. Set i_cfg_done=1 and pulse i_sof → FLUSH lasts 16 cycles, DRAIN sees empty=4'hF, o_reconfig_count=1, o_flush falls 1 cycle after the next SOF.
- **Mode change:** in RUN, toggle i_req_mode to 1 with no SOF for 1000 cycles → o_flush stays 0 and o_mode stays 0. Pulse SOF → 16 flush cycles, APPLY sets o_mode=1.
- **Threshold only:** change i_req_threshold to 26'd100 and pulse SOF → o_threshold=100 one cycle later, o_flush never rises, count unchanged.
- **Freeze while a change is pending:** set freeze and sobel=1 together, then pulse SOF → o_freeze=1, o_flush=1, o_sobel_enable=0. Release freeze → FLUSH/DRAIN/APPLY: o_sobel_enable=1, o_freeze=0.
- **Drain timeout:** hold i_empty=4'b0111 → APPLY occurs exactly 1024 cycles after DRAIN entry, o_timeout=1 and stays set through later passes.
- **Mid-operation events:** drop i_cfg_done during DRAIN → WAIT_CFG next cycle with o_flush=1. Assert db_rstn in FROZEN → all outputs at reset values within the same cycle.
